// File: rtl/hex_display_scan.sv
// hex_display_scan
//   Multiplexed scan controller for a DIGITS-wide common-anode 7-segment
//   display. Holds a double-buffered hex value, time-slices one nibble per
//   digit slot onto the shared decoder input and drives the active-low digit
//   enables. New values are latched into a pending buffer at any time and
//   only become visible at a frame boundary, so a frame never shows a mix of
//   old and new digits.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_enable       1 = scan; 0 = blank display and freeze the scan position
//   i_load         one-cycle strobe, captures i_value into the pending buffer
//   i_value        hex value, nibble i belongs to digit i (digit 0 = LSD)
//   i_blank_lz     1 = suppress leading zero digits (digit 0 always shown)
//   o_nibble       digit code to the hex-to-7-segment decoder (bit0 = A)
//   o_an           digit enables, active-low, bit i = digit i
//   o_digit_idx    index of the digit currently driven
//   o_frame_tick   one-cycle pulse in the cycle after each frame boundary
module hex_display_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_enable,
  input  logic                        i_load,
  input  logic [4*DIGITS-1:0]         i_value,
  input  logic                        i_blank_lz,
  output logic [3:0]                  o_nibble,
  output logic [DIGITS-1:0]           o_an,
  output logic [$clog2(DIGITS)-1:0]   o_digit_idx,
  output logic                        o_frame_tick
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [4*DIGITS-1:0]  r_active;
  logic [4*DIGITS-1:0]  r_pending;
  logic                 r_pend_flag;

  logic                 w_slot_end;
  logic                 w_boundary;
  logic [3:0]           w_cur_nib;
  logic [DIGITS-1:0]    w_blank;
  logic                 w_zero_above;
  logic [DIGITS-1:0]    w_an_next;

  assign w_slot_end = i_enable && (r_cnt == CNT_LAST);
  assign w_boundary = w_slot_end && (r_idx == IDX_LAST);

  // Walk from the most significant digit down: a digit is a leading zero
  // when it and every digit above it are zero. Digit 0 is never blanked.
  always_comb begin
    w_cur_nib    = 4'h0;
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_above = w_zero_above & (r_active[4*i +: 4] == 4'h0);
      if (i != 0) begin
        w_blank[i] = i_blank_lz & w_zero_above;
      end
      if (r_idx == IW'(i)) begin
        w_cur_nib = r_active[4*i +: 4];
      end
    end
  end

  always_comb begin
    w_an_next = '1;
    if (i_enable && !w_blank[r_idx]) begin
      w_an_next[r_idx] = 1'b0;
    end
  end

  // Slot prescaler and digit index; both freeze while scanning is disabled
  // so a re-enable resumes the same digit with its remaining slot time.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (i_enable) begin
      if (w_slot_end) begin
        r_cnt <= '0;
        if (r_idx == IDX_LAST) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Double buffer. On a boundary the commit uses the pending contents from
  // before the edge; a load on that same edge refills pending and keeps the
  // flag set so the new value lands one frame later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_flag <= 1'b0;
    end else begin
      if (w_boundary && r_pend_flag) begin
        r_active <= r_pending;
      end
      if (i_load) begin
        r_pending   <= i_value;
        r_pend_flag <= 1'b1;
      end else if (w_boundary) begin
        r_pend_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_nibble     <= 4'h0;
      o_an         <= '1;
      o_digit_idx  <= '0;
      o_frame_tick <= 1'b0;
    end else begin
      o_nibble     <= w_cur_nib;
      o_an         <= w_an_next;
      o_digit_idx  <= r_idx;
      o_frame_tick <= w_boundary;
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Testbench for hex_display_scan with DIGITS=4, PRESCALE=4.
module tb_hex_display_scan;

  localparam int D = 4;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ld;
  logic [15:0] val;
  logic        blz;
  logic [3:0]  nib;
  logic [3:0]  an;
  logic [1:0]  didx;
  logic        tick;

  always #5 clk = ~clk;

  hex_display_scan #(.DIGITS(D), .PRESCALE(P)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (en),
    .i_load       (ld),
    .i_value      (val),
    .i_blank_lz   (blz),
    .o_nibble     (nib),
    .o_an         (an),
    .o_digit_idx  (didx),
    .o_frame_tick (tick)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: scan position as a single count of enabled cycles
  // within a frame; digit = pos / P.
  int          m_pos;
  logic [15:0] m_act;
  logic [15:0] m_pend;
  bit          m_pf;
  logic [3:0]  e_nib;
  logic [3:0]  e_an;
  logic [1:0]  e_idx;
  logic        e_tick;

  function automatic logic [3:0] an_for(int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  function automatic bit m_blank(int i);
    if (!blz || i == 0) return 1'b0;
    return (m_act >> (4 * i)) == 16'h0;
  endfunction

  task automatic model_reset();
    m_pos  = 0;
    m_act  = 16'h0;
    m_pend = 16'h0;
    m_pf   = 1'b0;
  endtask

  task automatic model_edge();
    int i;
    i      = m_pos / P;
    e_nib  = m_act[4*i +: 4];
    e_idx  = i[1:0];
    e_an   = (en && !m_blank(i)) ? an_for(i) : 4'hF;
    e_tick = en && (m_pos == P * D - 1);
    if (en) m_pos = (m_pos + 1) % (P * D);
    if (e_tick && m_pf) begin
      m_act = m_pend;
      m_pf  = 1'b0;
    end
    if (ld) begin
      m_pend = val;
      m_pf   = 1'b1;
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] x_an,
                           input logic [3:0] x_nib, input logic [1:0] x_idx,
                           input logic x_tick);
    n_tests++;
    if (an !== x_an || nib !== x_nib || didx !== x_idx || tick !== x_tick) begin
      n_fail++;
      $display("FAIL %s: got an=%b nib=%h idx=%0d tick=%b, want an=%b nib=%h idx=%0d tick=%b",
               name, an, nib, didx, tick, x_an, x_nib, x_idx, x_tick);
    end
  endtask

  task automatic step(input bit chk);
    @(posedge clk);
    model_edge();
    #1;
    if (chk) check_out("model", e_an, e_nib, e_idx, e_tick);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_out("async_reset", 4'hF, 4'h0, 2'd0, 1'b0);
    model_reset();
    ld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        en;
    logic        blz;
    logic        ld;
    logic [15:0] val;
    int          ncyc;
    logic [3:0]  an;
    logic [3:0]  nib;
    logic [1:0]  idx;
    logic        tick;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [15:0] cd;
    logic [3:0]  x_nib;
    int          di;

    rst = 1'b1; en = 1'b0; ld = 1'b0; val = 16'h0; blz = 1'b0;
    model_reset();
    #3;
    check_out("reset_state", 4'hF, 4'h0, 2'd0, 1'b0);
    @(posedge clk); @(posedge clk);
    #1;
    rst = 1'b0;

    // Edge numbers in comments count clock edges since reset release.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'h1234, 1,  4'b1110, 4'h0, 2'd0, 1'b0}; // e1
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4,  4'b1101, 4'h0, 2'd1, 1'b0}; // e5
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 11, 4'b0111, 4'h0, 2'd3, 1'b1}; // e16
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1,  4'b1110, 4'h4, 2'd0, 1'b0}; // e17
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4,  4'b1101, 4'h3, 2'd1, 1'b0}; // e21
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4,  4'b1011, 4'h2, 2'd2, 1'b0}; // e25
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4,  4'b0111, 4'h1, 2'd3, 1'b0}; // e29
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4,  4'b1110, 4'h4, 2'd0, 1'b0}; // e33
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 16'h0050, 15, 4'b0111, 4'h1, 2'd3, 1'b1}; // e48
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1,  4'b1110, 4'h0, 2'd0, 1'b0}; // e49
    tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h0000, 4,  4'b1101, 4'h5, 2'd1, 1'b0}; // e53
    tbl[11] = '{1'b1, 1'b1, 1'b0, 16'h0000, 4,  4'b1111, 4'h0, 2'd2, 1'b0}; // e57
    tbl[12] = '{1'b1, 1'b1, 1'b0, 16'h0000, 4,  4'b1111, 4'h0, 2'd3, 1'b0}; // e61
    tbl[13] = '{1'b1, 1'b1, 1'b1, 16'h0000, 4,  4'b1110, 4'h0, 2'd0, 1'b0}; // e65
    tbl[14] = '{1'b1, 1'b1, 1'b0, 16'h0000, 4,  4'b1111, 4'h0, 2'd1, 1'b0}; // e69

    for (int k = 0; k < 15; k++) begin
      en  = tbl[k].en;
      blz = tbl[k].blz;
      ld  = tbl[k].ld;
      val = tbl[k].val;
      for (int c = 0; c < tbl[k].ncyc; c++) begin
        step(1'b0);
        ld = 1'b0;
      end
      check_out($sformatf("vec%0d", k), tbl[k].an, tbl[k].nib, tbl[k].idx, tbl[k].tick);
    end

    // Last load wins within a frame; the intermediate value never shows.
    blz = 1'b0;
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      ld  = (e == 3 || e == 5);
      val = (e == 3) ? 16'hAAAA : 16'hBBBB;
      step(1'b0);
      ld = 1'b0;
      di = ((e - 1) / P) % D;
      check_out($sformatf("last_wins_e%0d", e), an_for(di),
                (e <= 16) ? 4'h0 : 4'hB, di[1:0], e == 16 || e == 32);
    end

    // Load on the boundary edge while 1111 is pending; reset mid-frame later
    // with 5555 still pending.
    do_reset();
    cd = 16'hC0DE;
    for (int e = 1; e <= 40; e++) begin
      ld  = (e == 10 || e == 16 || e == 38);
      val = (e == 10) ? 16'h1111 : (e == 16) ? 16'hC0DE : 16'h5555;
      step(1'b0);
      ld = 1'b0;
      di = ((e - 1) / P) % D;
      x_nib = (e <= 16) ? 4'h0 : (e <= 32) ? 4'h1 : cd[4*di +: 4];
      check_out($sformatf("bnd_load_e%0d", e), an_for(di), x_nib, di[1:0],
                e == 16 || e == 32);
    end

    // Reset mid-frame (nibble is D here), then the pause/resume sequence.
    do_reset();
    step(1'b0);
    check_out("first_after_rst", 4'b1110, 4'h0, 2'd0, 1'b0);
    repeat (5) step(1'b0);
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0);
      check_out($sformatf("paused%0d", c), 4'hF, 4'h0, 2'd1, 1'b0);
    end
    en = 1'b1;
    step(1'b0);
    check_out("resume0", 4'b1101, 4'h0, 2'd1, 1'b0);
    step(1'b0);
    check_out("resume1", 4'b1101, 4'h0, 2'd1, 1'b0);
    step(1'b0);
    check_out("resume2", 4'b1011, 4'h0, 2'd2, 1'b0);
    // Pending 5555 was discarded by reset: past the next boundary still 0.
    repeat (12) step(1'b1);

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      en  = ($urandom_range(9) != 0);
      ld  = ($urandom_range(5) == 0);
      val = 16'($urandom);
      if ($urandom_range(39) == 0) blz = ~blz;
      if ($urandom_range(4) == 0) val[15:8] = 8'h00;
      if ($urandom_range(499) == 0) do_reset();
      step(1'b1);
      ld = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
Multiplexed scan controller for a DIGITS-wide common-anode 7-segment display. It sits directly upstream of the team's hex-to-7-segment decoder.
- Holds a double-buffered hex value and time-slices one nibble per digit slot onto the shared decoder input.
- Drives the active-low digit enables.
- New values are accepted at any time but take effect only at frame boundaries, so the display never tears.

Parameters:
DIGITS, 4, number of display digits (>=2)
PRESCALE, 50000, clock cycles per digit slot (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
enable  input  1  scanning enabled; 0 blanks the display and freezes the scan
load  input  1  one-cycle strobe; captures value into the pending buffer
value  input  4*DIGITS  hex value; nibble i drives digit i, digit 0 is least significant
blank_lz  input  1  1 = suppress leading zero digits
nibble  output  4  current digit code to decoder; bit0 feeds decoder input A, bit3 feeds D
an  output  DIGITS  digit enables, active-low; bit i = digit i
digit_idx  output  clog2(DIGITS)  index of the digit currently being driven
frame_tick  output  1  one-cycle pulse in the cycle after each frame boundary

Behaviour:
- Reset is asynchronous, active-high, and clears every register immediately:
  - prescaler cnt=0, idx=0
  - active=0, pending=0, pend_flag=0
  - an=all ones, nibble=0, digit_idx=0, frame_tick=0
- Prescaler:
  - enable=1: cnt counts 0..PRESCALE-1.
  - At cnt==PRESCALE-1: cnt->0 and idx->idx+1, wrapping DIGITS-1 -> 0.
  - enable=0: cnt and idx hold their values.
- Frame boundary: the clock edge where idx wraps from DIGITS-1 to 0.
- Load:
  - load=1 writes value to pending and sets pend_flag.
  - Multiple loads within one frame: last one wins; intermediate values are never displayed.
- Commit: at a frame boundary with pend_flag=1, active<=pending and pend_flag clears.
- Simultaneous load and boundary in the same cycle:
  - active takes the pending contents from before that edge.
  - pending takes the new value; pend_flag ends at 1, so the new value commits at the next boundary.
- Blanking: digit i is blank when blank_lz=1, i!=0, and active nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Outputs are registered and computed each cycle from the current idx/active/enable/blank_lz, so they lag idx by one cycle:
  - nibble <= active[4*idx+:4]
  - digit_idx <= idx
  - an <= all ones if enable=0 or digit idx is blanked; otherwise all ones with bit idx cleared.
  - frame_tick <= 1 exactly when the boundary edge occurred.
- At most one an bit is low in any cycle.
- Re-enable after a pause resumes the same digit with its remaining slot count.
- Reset asserted mid-frame discards both active and pending. Scanning restarts at digit 0 on the first clock edge after reset deasserts, showing 0.
- load is honoured regardless of enable.

Test Plan:
1. DIGITS=4, PRESCALE=4. Release reset, enable=1, blank_lz=0, no load -> an cycles 1110,1101,1011,0111, 4 cycles each, nibble=0 throughout; frame_tick pulses every 16 cycles.
2. Load 16'h1234 in the cycle after reset release -> first frame shows all zeros. After the first frame_tick, nibble sequence is 4,3,2,1 with an 1110,1101,1011,0111.
3. Load 16'hAAAA mid-frame, then 16'hBBBB two cycles later -> old value is shown until the boundary, then B on every digit; A never appears on nibble.
4. Load 16'hC0DE asserted exactly on the boundary edge, with pending=16'h1111 -> the next frame shows 1,1,1,1, and the frame after shows E,D,0,C.
5. blank_lz=1 with active 16'h0050 -> slots 2 and 3 give an=1111; slots 0 and 1 show 0 and 5. With active 16'h0000 -> only digit 0 is lit, showing 0.
6. Drop enable mid-slot for 10 cycles -> an=1111 from the next cycle and digit_idx is frozen. On re-enable the same digit resumes for its remaining count. Assert rst mid-frame -> an=1111, nibble=0, digit_idx=0 immediately, without waiting for a clock.
